// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
package mips_cpu_pkg;

  // Control FSM state register encoding (5 and 7 are unused).
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC1  = 3'd3,
    ST_EXEC2  = 3'd4,
    ST_HALT   = 3'd6
  } state_t;

  // Instruction classes produced by the decoder; the FSM sequences on these.
  typedef enum logic [3:0] {
    IC_RTYPE,
    IC_IMM,
    IC_LW,
    IC_SW,
    IC_BEQ,
    IC_BNE,
    IC_J,
    IC_JAL,
    IC_JR,
    IC_JALR,
    IC_BAD
  } iclass_t;

  // Primary opcodes (instruction[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instruction[5:0]).
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_ALU_LO = 6'h20;
  localparam logic [5:0] FN_ALU_HI = 6'h2B;

  // ALU operation classes.
  localparam logic [3:0] ALUOP_ADD   = 4'd0;
  localparam logic [3:0] ALUOP_SUB   = 4'd1;
  localparam logic [3:0] ALUOP_FUNCT = 4'd2;
  localparam logic [3:0] ALUOP_IMM   = 4'd3;

  // PC source mux selects.
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  // ALU operand B mux selects.
  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  // Register-file destination selects.
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // States that issue a bus access and can therefore be stretched by waitrequest.
  function automatic logic is_mem_state(state_t s, iclass_t c);
    return (s == ST_FETCH) ||
           (s == ST_EXEC1 && c == IC_LW) ||
           (s == ST_EXEC2 && c == IC_SW);
  endfunction

endpackage

// File: rtl/mips_cpu_control_fsm_if.sv
// Memory bus handshake between the control FSM (master) and the bus.
interface mips_cpu_control_fsm_if;
  logic memread;
  logic memwrite;
  logic mem_waitrequest;

  modport master (output memread, output memwrite, input mem_waitrequest);
  modport slave  (input memread, input memwrite, output mem_waitrequest);
endinterface

// File: rtl/mips_cpu_instr_decode.sv
// Maps opcode/fncode to an instruction class; disabled groups decode as IC_BAD.
module mips_cpu_instr_decode
  import mips_cpu_pkg::*;
#(
  parameter int ENABLE_IMM  = 1,
  parameter int ENABLE_JUMP = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] fncode,
  output iclass_t    iclass,
  output logic       supported
);

  // Pure lookup; anything not listed is unsupported.
  always_comb begin
    iclass = IC_BAD;
    case (opcode)
      OP_RTYPE: begin
        if (fncode >= FN_ALU_LO && fncode <= FN_ALU_HI) iclass = IC_RTYPE;
        else if (fncode == FN_JR)                      iclass = IC_JR;
        else if (fncode == FN_JALR)                    iclass = IC_JALR;
      end
      OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        if (ENABLE_IMM != 0) iclass = IC_IMM;
      end
      OP_LW:  iclass = IC_LW;
      OP_SW:  iclass = IC_SW;
      OP_BEQ: iclass = IC_BEQ;
      OP_BNE: iclass = IC_BNE;
      OP_J: begin
        if (ENABLE_JUMP != 0) iclass = IC_J;
      end
      OP_JAL: begin
        if (ENABLE_JUMP != 0) iclass = IC_JAL;
      end
      default: iclass = IC_BAD;
    endcase
  end

  assign supported = (iclass != IC_BAD);

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXEC1/EXEC2 sequencing, datapath
// strobes, waitrequest stretching with timeout, and halt/fault handling.
module mips_cpu_control_fsm
  import mips_cpu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int ENABLE_IMM   = 1,
  parameter int ENABLE_JUMP  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             opcode,
  input  logic [5:0]             fncode,
  input  logic                   jump_target_zero,
  mips_cpu_control_fsm_if.master mem,
  output logic [2:0]             state,
  output logic [1:0]             regdst,
  output logic                   regwrite,
  output logic                   iord,
  output logic                   irwrite,
  output logic                   pcwrite,
  output logic                   pcwritecond,
  output logic                   pcwritecond_ne,
  output logic [1:0]             pcsource,
  output logic                   memtoreg,
  output logic [3:0]             aluop,
  output logic                   alusrca,
  output logic [1:0]             alusrcb,
  output logic                   active,
  output logic                   fault
);

  localparam logic [7:0] WAIT_MAX_C = 8'(MEM_WAIT_MAX);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       fault_reg, fault_next;
  iclass_t    iclass;
  logic       supported;
  logic       wait_req;
  logic       mem_state;
  logic       timeout;
  logic       memread_c, memwrite_c;

  mips_cpu_instr_decode #(
    .ENABLE_IMM  (ENABLE_IMM),
    .ENABLE_JUMP (ENABLE_JUMP)
  ) u_decode (
    .opcode    (opcode),
    .fncode    (fncode),
    .iclass    (iclass),
    .supported (supported)
  );

  assign wait_req  = mem.mem_waitrequest;
  assign mem_state = is_mem_state(state_reg, iclass);
  // Held long enough: this cycle aborts the access and goes to HALT.
  assign timeout   = mem_state && (wait_cnt_reg == WAIT_MAX_C);

  // Next-state, fault and strobe decode from state plus instruction class.
  always_comb begin
    state_next     = state_reg;
    fault_next     = fault_reg;
    regdst         = REGDST_RT;
    regwrite       = 1'b0;
    iord           = 1'b0;
    irwrite        = 1'b0;
    pcwrite        = 1'b0;
    pcwritecond    = 1'b0;
    pcwritecond_ne = 1'b0;
    pcsource       = PCSRC_ALU;
    memread_c      = 1'b0;
    memwrite_c     = 1'b0;
    memtoreg       = 1'b0;
    aluop          = ALUOP_ADD;
    alusrca        = 1'b0;
    alusrcb        = SRCB_B;

    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;

      ST_FETCH: begin
        if (timeout) begin
          state_next = ST_HALT;
          fault_next = 1'b1;
        end else begin
          memread_c = 1'b1;
          alusrcb   = SRCB_FOUR;
          irwrite   = !wait_req;
          pcwrite   = !wait_req;
          if (!wait_req) state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // Branch target is precomputed here whatever the instruction.
        alusrcb = SRCB_IMMSH;
        if (!supported) begin
          state_next = ST_HALT;
          fault_next = 1'b1;
        end else begin
          state_next = ST_EXEC1;
        end
      end

      ST_EXEC1: begin
        case (iclass)
          IC_RTYPE: begin
            alusrca    = 1'b1;
            aluop      = ALUOP_FUNCT;
            state_next = ST_EXEC2;
          end
          IC_IMM: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_IMM;
            aluop      = ALUOP_IMM;
            state_next = ST_EXEC2;
          end
          IC_LW: begin
            if (timeout) begin
              state_next = ST_HALT;
              fault_next = 1'b1;
            end else begin
              iord      = 1'b1;
              memread_c = 1'b1;
              alusrca   = 1'b1;
              alusrcb   = SRCB_IMM;
              if (!wait_req) state_next = ST_EXEC2;
            end
          end
          IC_SW: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_IMM;
            state_next = ST_EXEC2;
          end
          IC_BEQ, IC_BNE: begin
            alusrca        = 1'b1;
            aluop          = ALUOP_SUB;
            pcsource       = PCSRC_ALUOUT;
            pcwritecond    = (iclass == IC_BEQ);
            pcwritecond_ne = (iclass == IC_BNE);
            state_next     = ST_FETCH;
          end
          IC_J, IC_JAL: begin
            pcwrite    = 1'b1;
            pcsource   = PCSRC_JUMP;
            if (iclass == IC_JAL) begin
              regdst   = REGDST_RA;
              regwrite = 1'b1;
            end
            state_next = ST_FETCH;
          end
          IC_JR: state_next = ST_EXEC2;
          IC_JALR: begin
            regdst     = REGDST_RD;
            regwrite   = 1'b1;
            state_next = ST_EXEC2;
          end
          default: begin
            // IR changed under us; nothing sensible to execute.
            state_next = ST_HALT;
            fault_next = 1'b1;
          end
        endcase
      end

      ST_EXEC2: begin
        case (iclass)
          IC_RTYPE: begin
            regdst     = REGDST_RD;
            regwrite   = 1'b1;
            state_next = ST_FETCH;
          end
          IC_IMM: begin
            regwrite   = 1'b1;
            state_next = ST_FETCH;
          end
          IC_LW: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            state_next = ST_FETCH;
          end
          IC_SW: begin
            if (timeout) begin
              state_next = ST_HALT;
              fault_next = 1'b1;
            end else begin
              iord       = 1'b1;
              memwrite_c = 1'b1;
              if (!wait_req) state_next = ST_FETCH;
            end
          end
          IC_JR, IC_JALR: begin
            // A jump to address zero is the program's clean exit.
            pcwrite    = 1'b1;
            pcsource   = PCSRC_REGA;
            state_next = jump_target_zero ? ST_HALT : ST_FETCH;
          end
          default: begin
            state_next = ST_HALT;
            fault_next = 1'b1;
          end
        endcase
      end

      ST_HALT: state_next = ST_HALT;

      default: begin
        state_next = ST_HALT;
        fault_next = 1'b1;
      end
    endcase

    // Count cycles a bus access is stretched; any state change restarts it.
    if (state_next != state_reg)        wait_cnt_next = 8'd0;
    else if (mem_state && wait_req)     wait_cnt_next = wait_cnt_reg + 8'd1;
    else                                wait_cnt_next = wait_cnt_reg;
  end

  // State, wait counter and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 8'd0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      fault_reg    <= fault_next;
    end
  end

  assign state        = state_reg;
  assign fault        = fault_reg;
  assign active       = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
  assign mem.memread  = memread_c;
  assign mem.memwrite = memwrite_c;

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// Bench for mips_cpu_control_fsm: directed scenarios plus randomized
// instructions, checked against a per-instruction cycle/strobe model.
module tb_mips_cpu_control_fsm;

  localparam int WMAX = 15;

  // Instruction classes as the bench models them.
  localparam int K_R = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
  localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9, K_BAD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] fncode = 6'd0;
  logic       jtz = 1'b0;
  logic [2:0] state;
  logic [1:0] regdst, pcsource, alusrcb;
  logic [3:0] aluop;
  logic regwrite, iord, irwrite, pcwrite, pcwritecond, pcwritecond_ne;
  logic memtoreg, alusrca, active, fault;

  int checks = 0;
  int failures = 0;

  mips_cpu_control_fsm_if bus();

  mips_cpu_control_fsm #(
    .MEM_WAIT_MAX (WMAX),
    .ENABLE_IMM   (1),
    .ENABLE_JUMP  (1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .opcode           (opcode),
    .fncode           (fncode),
    .jump_target_zero (jtz),
    .mem              (bus),
    .state            (state),
    .regdst           (regdst),
    .regwrite         (regwrite),
    .iord             (iord),
    .irwrite          (irwrite),
    .pcwrite          (pcwrite),
    .pcwritecond      (pcwritecond),
    .pcwritecond_ne   (pcwritecond_ne),
    .pcsource         (pcsource),
    .memtoreg         (memtoreg),
    .aluop            (aluop),
    .alusrca          (alusrca),
    .alusrcb          (alusrcb),
    .active           (active),
    .fault            (fault)
  );

  wire [19:0] strobes = {regdst, regwrite, iord, irwrite, pcwrite, pcwritecond,
                         pcwritecond_ne, pcsource, bus.memread, bus.memwrite,
                         memtoreg, aluop, alusrca, alusrcb};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn >= 6'h20 && fn <= 6'h2B) return K_R;
        if (fn == 6'h08) return K_JR;
        if (fn == 6'h09) return K_JALR;
        return K_BAD;
      end
      6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: return K_IMM;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_BAD;
    endcase
  endfunction

  // Reset, check the idle outputs, release, and land in FETCH.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_waitrequest = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_active", active, 0);
    chk("rst_fault", fault, 0);
    chk("rst_strobes", strobes, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_idle_after_release", state, 0);
    @(posedge clk);
    #1;
    chk("rst_then_fetch", state, 1);
    chk("rst_then_active", active, 1);
  endtask

  // Execute one instruction starting in FETCH; the bus stalls the fetch wf
  // cycles and any data access wm cycles. Outcome is compared to the model.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                           input int wm, input logic jz, input string tag);
    int k, wait_left, bad, n_rw, n_irw, n_pcw, n_pcc, n_pcn, n_mr, n_mw, n_iord, n_inact;
    int exp_seq[$];
    int seq[$];
    int exp_rw, exp_pcw, exp_mr, exp_mw, exp_end, exp_rd, exp_mtr, exp_ps;
    logic [8:0] fetch_cap, exp_fetch;
    logic [5:0] dec_cap;
    logic [6:0] e1_cap, exp_e1;
    logic [2:0] rd_cap, mtr_cap, ps_cap;
    bit e1_seen, done;

    k = classify(op, fn);
    n_rw = 0; n_irw = 0; n_pcw = 0; n_pcc = 0; n_pcn = 0; n_mr = 0; n_mw = 0;
    n_iord = 0; n_inact = 0;
    fetch_cap = 9'h1FF; dec_cap = 6'h3F; e1_cap = 7'h7F;
    rd_cap = 3'd7; mtr_cap = 3'd7; ps_cap = 3'd7;
    e1_seen = 1'b0; done = 1'b0;

    // Expected state trace and per-instruction strobe totals.
    repeat (wf + 1) exp_seq.push_back(1);
    exp_seq.push_back(2);
    case (k)
      K_R, K_IMM, K_JR, K_JALR: begin exp_seq.push_back(3); exp_seq.push_back(4); end
      K_LW: begin repeat (wm + 1) exp_seq.push_back(3); exp_seq.push_back(4); end
      K_SW: begin exp_seq.push_back(3); repeat (wm + 1) exp_seq.push_back(4); end
      K_BEQ, K_BNE, K_J, K_JAL: exp_seq.push_back(3);
      default: ;
    endcase
    exp_rw  = (k == K_R || k == K_IMM || k == K_LW || k == K_JAL || k == K_JALR) ? 1 : 0;
    exp_pcw = 1 + ((k == K_J || k == K_JAL || k == K_JR || k == K_JALR) ? 1 : 0);
    exp_mr  = wf + 1 + ((k == K_LW) ? wm + 1 : 0);
    exp_mw  = (k == K_SW) ? wm + 1 : 0;
    exp_end = (k == K_BAD || ((k == K_JR || k == K_JALR) && jz)) ? 6 : 1;
    case (k)
      K_R, K_JALR: exp_rd = 1;
      K_JAL:       exp_rd = 2;
      K_IMM, K_LW: exp_rd = 0;
      default:     exp_rd = 7;
    endcase
    exp_mtr = (exp_rw == 0) ? 7 : ((k == K_LW) ? 1 : 0);
    case (k)
      K_BEQ, K_BNE:  exp_ps = 1;
      K_J, K_JAL:    exp_ps = 2;
      K_JR, K_JALR:  exp_ps = 3;
      default:       exp_ps = 7;
    endcase
    // {alusrca, alusrcb, aluop} seen on the first EXEC1 cycle.
    case (k)
      K_R:          exp_e1 = {1'b1, 2'd0, 4'd2};
      K_IMM:        exp_e1 = {1'b1, 2'd2, 4'd3};
      K_LW, K_SW:   exp_e1 = {1'b1, 2'd2, 4'd0};
      K_BEQ, K_BNE: exp_e1 = {1'b1, 2'd0, 4'd1};
      K_BAD:        exp_e1 = 7'h7F;
      default:      exp_e1 = 7'h00;
    endcase
    exp_fetch = {2'd0, 2'd1, 1'b0, 4'd0};

    opcode = op; fncode = fn; jtz = jz;
    wait_left = wf;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if ((bus.memread || bus.memwrite) && wait_left > 0) begin
        bus.mem_waitrequest = 1'b1;
        wait_left--;
      end else begin
        bus.mem_waitrequest = 1'b0;
        if (bus.memread || bus.memwrite) wait_left = wm;
      end
      #1;
      seq.push_back(int'(state));
      if (regwrite) begin n_rw++; rd_cap = {1'b0, regdst}; mtr_cap = {2'b0, memtoreg}; end
      if (irwrite) n_irw++;
      if (pcwrite) n_pcw++;
      if (pcwritecond) n_pcc++;
      if (pcwritecond_ne) n_pcn++;
      if (bus.memread) n_mr++;
      if (bus.memwrite) n_mw++;
      if ((bus.memread || bus.memwrite) && (iord != (state != 3'd1))) n_iord++;
      if (state == 3'd1 && irwrite) fetch_cap = {pcsource, alusrcb, alusrca, aluop};
      if (state == 3'd2) dec_cap = {alusrcb, aluop};
      if (state == 3'd3 && !e1_seen) begin e1_cap = {alusrca, alusrcb, aluop}; e1_seen = 1'b1; end
      if (state != 3'd1 && (pcwrite || pcwritecond || pcwritecond_ne)) ps_cap = {1'b0, pcsource};
      if (!active) n_inact++;
      @(posedge clk);
      #1;
      if (state == 3'd6 || (state == 3'd1 && seq[seq.size()-1] != 1)) done = 1'b1;
    end
    bus.mem_waitrequest = 1'b0;

    bad = (seq.size() != exp_seq.size()) ? 1 : 0;
    if (bad == 0) foreach (seq[i]) if (seq[i] != exp_seq[i]) bad++;
    $display("txn %s op=%h fn=%h wf=%0d wm=%0d jz=%0d cycles=%0d end_state=%0d fault=%0d",
             tag, op, fn, wf, wm, jz, seq.size(), state, fault);
    chk({tag, "_finished"}, done, 1);
    chk({tag, "_trace_len"}, seq.size(), exp_seq.size());
    chk({tag, "_trace_bad"}, bad, 0);
    chk({tag, "_irwrite"}, n_irw, 1);
    chk({tag, "_pcwrite"}, n_pcw, exp_pcw);
    chk({tag, "_regwrite"}, n_rw, exp_rw);
    chk({tag, "_memread"}, n_mr, exp_mr);
    chk({tag, "_memwrite"}, n_mw, exp_mw);
    chk({tag, "_pcwritecond"}, n_pcc, (k == K_BEQ) ? 1 : 0);
    chk({tag, "_pcwritecond_ne"}, n_pcn, (k == K_BNE) ? 1 : 0);
    chk({tag, "_iord"}, n_iord, 0);
    chk({tag, "_fetch_sel"}, fetch_cap, exp_fetch);
    chk({tag, "_decode_sel"}, dec_cap, {2'd3, 4'd0});
    chk({tag, "_exec1_sel"}, e1_cap, exp_e1);
    chk({tag, "_regdst"}, rd_cap, exp_rd);
    chk({tag, "_memtoreg"}, mtr_cap, exp_mtr);
    chk({tag, "_pcsource"}, ps_cap, exp_ps);
    chk({tag, "_inactive"}, n_inact, 0);
    chk({tag, "_end_state"}, state, exp_end);
    chk({tag, "_fault"}, fault, (k == K_BAD) ? 1 : 0);
    chk({tag, "_active_end"}, active, (exp_end == 6) ? 0 : 1);
    if (state == 3'd6) chk({tag, "_halt_strobes"}, strobes, 0);
  endtask

  initial begin
    int n_fetch, n_irw, n_mr, sel, wf, wm;
    logic last_mr, jz, found;
    logic [5:0] op, fn;

    do_reset();

    run_instr(6'h00, 6'h21, 0, 0, 1'b0, "addu");
    run_instr(6'h23, 6'h00, 0, 3, 1'b0, "lw_wait3");
    run_instr(6'h04, 6'h00, 0, 0, 1'b0, "beq");
    run_instr(6'h05, 6'h00, 0, 0, 1'b0, "bne");
    run_instr(6'h2B, 6'h00, 1, 2, 1'b0, "sw_wait");
    run_instr(6'h03, 6'h00, 0, 0, 1'b0, "jal");
    run_instr(6'h00, 6'h08, 0, 0, 1'b1, "jr_zero");
    do_reset();
    run_instr(6'h3F, 6'h00, 0, 0, 1'b0, "bad_op");
    do_reset();

    // Fetch with waitrequest stuck high: timeout into HALT with fault.
    bus.mem_waitrequest = 1'b1;
    n_fetch = 0; n_irw = 0; n_mr = 0; last_mr = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      #1;
      if (state != 3'd1) break;
      n_fetch++;
      if (irwrite) n_irw++;
      if (bus.memread) n_mr++;
      last_mr = bus.memread;
    end
    $display("txn fetch_stuck fetch_cycles=%0d state=%0d fault=%0d", n_fetch, state, fault);
    chk("stuck_fetch_cycles", n_fetch, WMAX + 1);
    chk("stuck_memread_cycles", n_mr, WMAX);
    chk("stuck_timeout_memread", last_mr, 0);
    chk("stuck_irwrite", n_irw, 0);
    chk("stuck_state", state, 6);
    chk("stuck_fault", fault, 1);
    chk("stuck_active", active, 0);
    bus.mem_waitrequest = 1'b0;
    do_reset();

    // Reset asserted while sw is writing in EXEC2.
    opcode = 6'h2B; fncode = 6'h00; jtz = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      bus.mem_waitrequest = (state == 3'd4);
      #1;
      if (state == 3'd4 && bus.memwrite) found = 1'b1;
    end
    chk("swrst_reached_write", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn sw_reset_mid state=%0d memwrite=%0d", state, bus.memwrite);
    chk("swrst_state", state, 0);
    chk("swrst_memwrite", bus.memwrite, 0);
    chk("swrst_fault", fault, 0);
    chk("swrst_strobes", strobes, 0);
    @(negedge clk);
    bus.mem_waitrequest = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("swrst_restart_fetch", state, 1);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 21);
      fn = 6'h00;
      case (sel)
        0: begin op = 6'h00; fn = 6'h21; end
        1: begin op = 6'h00; fn = 6'h20; end
        2: begin op = 6'h00; fn = 6'h2A; end
        3: begin op = 6'h00; fn = 6'h2B; end
        4: op = 6'h09;
        5: op = 6'h0A;
        6: op = 6'h0C;
        7: op = 6'h0D;
        8: op = 6'h0E;
        9: op = 6'h23;
        10: op = 6'h2B;
        11: op = 6'h04;
        12: op = 6'h05;
        13: op = 6'h02;
        14: op = 6'h03;
        15: begin op = 6'h00; fn = 6'h08; end
        16: begin op = 6'h00; fn = 6'h09; end
        17: begin op = 6'h00; fn = 6'h00; end
        18: op = 6'h0B;
        19: op = 6'h3F;
        default: begin op = 6'($urandom); fn = 6'($urandom); end
      endcase
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      jz = ($urandom_range(0, 3) == 0);
      run_instr(op, fn, wf, wm, jz, "rand");
      if (state != 3'd1) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
